// File: rtl/wt_cache_ctrl_wbuf.sv
// Write-through cache controller with a posted-write buffer between the CPU port and memory.
// Writes drain in the background; read misses drain the buffer before fetching the line.
module wt_cache_ctrl_wbuf #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              hit,
  input  logic              ready,
  output logic              stall,
  output logic              refill,
  output logic              update,
  output logic              main_read,
  output logic              main_write,
  output logic [ADDR_W-1:0] main_addr,
  output logic [DATA_W-1:0] main_wdata,
  output logic              wb_empty
);

  // state  | meaning
  // IDLE   | serve CPU hits/writes, drain buffer in background
  // DRAIN  | read miss pending, emptying buffer to keep ordering
  // RD_REQ | fetching the missed line from memory
  // REFILL | one-cycle cache line write, then back to IDLE

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, RD_REQ, REFILL} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [DATA_W-1:0] wb_data [WB_DEPTH];

  logic full, push, pop, drain_active, last_pop;

  assign full     = (count == CNT_W'(WB_DEPTH));
  assign wb_empty = (count == '0);
  assign last_pop = pop && (count == CNT_W'(1));

  // Outputs are forced low while reset is held so they clear without a clock edge.
  always_comb begin
    stall        = 1'b0;
    refill       = 1'b0;
    update       = 1'b0;
    main_read    = 1'b0;
    main_write   = 1'b0;
    main_addr    = '0;
    main_wdata   = '0;
    push         = 1'b0;
    pop          = 1'b0;
    drain_active = 1'b0;
    if (reset) begin
      drain_active = ((state == IDLE) || (state == DRAIN)) && !wb_empty;
      if (drain_active) begin
        main_write = 1'b1;
        main_addr  = wb_addr[rd_ptr];
        main_wdata = wb_data[rd_ptr];
        pop        = ready;
      end
      case (state)
        IDLE: begin
          if (mem_read) begin
            stall = !hit;
          end else if (mem_write) begin
            if (full) begin
              stall = 1'b1;
            end else begin
              push   = 1'b1;
              update = hit;
            end
          end
        end
        DRAIN: stall = 1'b1;
        RD_REQ: begin
          stall     = 1'b1;
          main_read = 1'b1;
          main_addr = addr;
        end
        REFILL: begin
          stall  = 1'b1;
          refill = 1'b1;
        end
        default: stall = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(WB_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(WB_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case (state)
        IDLE: begin
          if (mem_read && !hit)
            state <= (wb_empty || last_pop) ? RD_REQ : DRAIN;
        end
        DRAIN:   if (wb_empty || last_pop) state <= RD_REQ;
        RD_REQ:  if (ready) state <= REFILL;
        REFILL:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wr_ptr] <= addr;
      wb_data[wr_ptr] <= wdata;
    end
  end

endmodule

// File: tb/tb_wt_cache_ctrl_wbuf.sv
// Directed bench: control outputs checked inline, memory write beats checked by a
// scoreboard monitor against the expected drain order. Depth 4 and depth 3 instances.
module tb_wt_cache_ctrl_wbuf;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, hit, ready;
  logic [31:0] addr, wdata;

  logic        stall4, refill4, update4, main_read4, main_write4, wb_empty4;
  logic [31:0] main_addr4, main_wdata4;
  logic        stall3, refill3, update3, main_read3, main_write3, wb_empty3;
  logic [31:0] main_addr3, main_wdata3;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon3_en  = 1'b0;

  typedef struct packed {logic [31:0] a; logic [31:0] d;} beat_t;
  beat_t q4[$];
  beat_t q3[$];
  beat_t e4, e3;

  always #5 clk = ~clk;

  wt_cache_ctrl_wbuf #(.ADDR_W(32), .DATA_W(32), .WB_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .hit(hit), .ready(ready),
    .stall(stall4), .refill(refill4), .update(update4), .main_read(main_read4),
    .main_write(main_write4), .main_addr(main_addr4), .main_wdata(main_wdata4),
    .wb_empty(wb_empty4));

  wt_cache_ctrl_wbuf #(.ADDR_W(32), .DATA_W(32), .WB_DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .hit(hit), .ready(ready),
    .stall(stall3), .refill(refill3), .update(update3), .main_read(main_read3),
    .main_write(main_write3), .main_addr(main_addr3), .main_wdata(main_wdata3),
    .wb_empty(wb_empty3));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic h, input logic rdy,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    hit       = h;
    ready     = rdy;
    addr      = a;
    wdata     = d;
    #2;
  endtask

  // Memory-side monitors: every accepted write beat must match the next expected entry.
  initial forever begin
    @(negedge clk); #3;
    if (reset && main_write4 && ready) begin
      n_checks++;
      if (q4.size() == 0) begin
        n_fail++;
        $display("FAIL beat4: unexpected write addr %0h data %0h", main_addr4, main_wdata4);
      end else begin
        e4 = q4.pop_front();
        if (main_addr4 !== e4.a || main_wdata4 !== e4.d) begin
          n_fail++;
          $display("FAIL beat4: got %0h/%0h expected %0h/%0h", main_addr4, main_wdata4, e4.a, e4.d);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk); #3;
    if (mon3_en && reset && main_write3 && ready) begin
      n_checks++;
      if (q3.size() == 0) begin
        n_fail++;
        $display("FAIL beat3: unexpected write addr %0h data %0h", main_addr3, main_wdata3);
      end else begin
        e3 = q3.pop_front();
        if (main_addr3 !== e3.a || main_wdata3 !== e3.d) begin
          n_fail++;
          $display("FAIL beat3: got %0h/%0h expected %0h/%0h", main_addr3, main_wdata3, e3.a, e3.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mem_read = 0; mem_write = 0; hit = 0; ready = 0; addr = 0; wdata = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_stall", {31'b0, stall4}, 0);
    chk("rst_wb_empty", {31'b0, wb_empty4}, 1);
    chk("rst_main_write", {31'b0, main_write4}, 0);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset in the middle of a line fetch
    drive(1, 0, 0, 0, 32'h80, 0);
    chk("t1_miss_stall", {31'b0, stall4}, 1);
    drive(1, 0, 0, 0, 32'h80, 0);
    chk("t1_rdreq_main_read", {31'b0, main_read4}, 1);
    chk("t1_rdreq_addr", main_addr4, 32'h80);
    #1 reset = 1'b0;
    #1;
    chk("t1_rst_stall", {31'b0, stall4}, 0);
    chk("t1_rst_main_read", {31'b0, main_read4}, 0);
    chk("t1_rst_main_addr", main_addr4, 0);
    chk("t1_rst_refill", {31'b0, refill4}, 0);
    chk("t1_rst_wb_empty", {31'b0, wb_empty4}, 1);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Write hit, then a single drain beat
    drive(0, 1, 1, 0, 32'h40, 32'hDEADBEEF);
    chk("t3_update", {31'b0, update4}, 1);
    chk("t3_stall", {31'b0, stall4}, 0);
    q4.push_back('{a: 32'h40, d: 32'hDEADBEEF});
    drive(0, 0, 0, 1, 0, 0);
    chk("t3_main_write", {31'b0, main_write4}, 1);
    chk("t3_main_addr", main_addr4, 32'h40);
    chk("t3_main_wdata", main_wdata4, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0);
    chk("t3_wb_empty", {31'b0, wb_empty4}, 1);

    // Fill the depth-4 buffer, fifth write stalls until the cycle after the first ready
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i));
      chk("t2_accept_stall", {31'b0, stall4}, 0);
      chk("t2_miss_update", {31'b0, update4}, 0);
      q4.push_back('{a: 32'h100 + 32'(4 * i), d: 32'hA0000000 + 32'(i)});
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 32'h110, 32'hA0000004);
      chk("t2_full_stall", {31'b0, stall4}, 1);
    end
    drive(0, 1, 0, 1, 32'h110, 32'hA0000004);
    chk("t2_full_pop_stall", {31'b0, stall4}, 1);
    drive(0, 1, 0, 0, 32'h110, 32'hA0000004);
    chk("t2_after_pop_stall", {31'b0, stall4}, 0);
    q4.push_back('{a: 32'h110, d: 32'hA0000004});
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_wb_empty", {31'b0, wb_empty4}, 1);

    // Read miss with two buffered writes
    drive(0, 1, 0, 0, 32'h200, 32'h11);
    q4.push_back('{a: 32'h200, d: 32'h11});
    drive(0, 1, 0, 0, 32'h204, 32'h22);
    q4.push_back('{a: 32'h204, d: 32'h22});
    drive(1, 0, 0, 0, 32'h80, 0);
    chk("t4_miss_stall", {31'b0, stall4}, 1);
    chk("t4_miss_main_read", {31'b0, main_read4}, 0);
    drive(1, 0, 0, 1, 32'h80, 0);
    chk("t4_drain1_write", {31'b0, main_write4}, 1);
    chk("t4_drain1_stall", {31'b0, stall4}, 1);
    drive(1, 0, 0, 1, 32'h80, 0);
    chk("t4_drain2_write", {31'b0, main_write4}, 1);
    chk("t4_drain2_read", {31'b0, main_read4}, 0);
    drive(1, 0, 0, 0, 32'h80, 0);
    chk("t4_rdreq_read", {31'b0, main_read4}, 1);
    chk("t4_rdreq_write", {31'b0, main_write4}, 0);
    chk("t4_rdreq_addr", main_addr4, 32'h80);
    drive(1, 0, 0, 1, 32'h80, 0);
    chk("t4_rdreq_ready_read", {31'b0, main_read4}, 1);
    drive(1, 0, 1, 0, 32'h80, 0);
    chk("t4_refill", {31'b0, refill4}, 1);
    chk("t4_refill_stall", {31'b0, stall4}, 1);
    drive(1, 0, 1, 0, 32'h80, 0);
    chk("t4_hit_refill", {31'b0, refill4}, 0);
    chk("t4_hit_stall", {31'b0, stall4}, 0);
    chk("t4_hit_main_read", {31'b0, main_read4}, 0);

    // Read and write together: read wins, write dropped
    drive(1, 1, 1, 0, 32'h300, 32'h55);
    chk("t5_stall", {31'b0, stall4}, 0);
    chk("t5_update", {31'b0, update4}, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_no_push", {31'b0, wb_empty4}, 1);
    chk("t5_no_main_write", {31'b0, main_write4}, 0);

    // Pointer wrap on depth 3 with memory always ready
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    mon3_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 1, 32'h400 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
      chk("t6_stall3", {31'b0, stall3}, 0);
      q3.push_back('{a: 32'h400 + 32'(4 * i), d: 32'hC0DE0000 + 32'(i)});
      q4.push_back('{a: 32'h400 + 32'(4 * i), d: 32'hC0DE0000 + 32'(i)});
    end
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_wb_empty3", {31'b0, wb_empty3}, 1);
    chk("t6_wb_empty4", {31'b0, wb_empty4}, 1);
    chk("q4_drained", 32'(q4.size()), 0);
    chk("q3_drained", 32'(q3.size()), 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
